// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch queue handshake bundle (imem, redirect, decode side)
interface fetch_queue_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int CNT_W = 3
);
  // instruction memory request/response
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;
  // branch redirect from EX
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  // decode handshake
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;
  logic             out_ready;
  // occupancy
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // fetch queue side
  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, count, full, empty,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );

  // memory / decode / EX side
  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, count, full, empty,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with in-order imem requests and redirect flush
module fetch_queue #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // run holds off the first request until the first edge after reset release
  logic             run;
  logic [PC_W-1:0]  fpc;

  // entry FIFO of fetched {pc, instr}
  logic [PC_W-1:0]  e_pc  [DEPTH];
  logic [INS_W-1:0] e_ins [DEPTH];
  logic [PTR_W-1:0] e_wr, e_rd;
  logic [CNT_W-1:0] e_cnt;

  // pending-PC FIFO of issued requests; its occupancy is inflight
  logic [PC_W-1:0]  p_pc  [DEPTH];
  logic [PTR_W-1:0] p_wr, p_rd;
  logic [CNT_W-1:0] inflight;

  // responses still owed by memory for requests killed by a redirect
  logic [CNT_W-1:0] drop;

  logic [CNT_W:0]   credits;
  logic             issue;
  logic             rsp_drop;
  logic             rsp_take;
  logic             out_valid_c;
  logic             accept;
  logic [CNT_W-1:0] drop_redir;

  // issue/response/accept decisions from pre-edge state
  always_comb begin
    credits     = {1'b0, e_cnt} + {1'b0, inflight} + {1'b0, drop};
    issue       = run && !fq.redirect && (credits < (CNT_W+1)'(DEPTH));
    rsp_drop    = fq.imem_rvalid && (drop != '0);
    rsp_take    = fq.imem_rvalid && (drop == '0) && (inflight != '0);
    out_valid_c = (e_cnt != '0) && !fq.redirect;
    accept      = out_valid_c && fq.out_ready;
    // everything outstanding becomes stale; a response arriving now is itself discarded
    drop_redir  = drop + inflight
                - CNT_W'(fq.imem_rvalid && ((drop != '0) || (inflight != '0)));
  end

  assign fq.imem_req  = issue;
  assign fq.imem_addr = fpc;
  assign fq.out_valid = out_valid_c;
  assign fq.out_pc    = out_valid_c ? e_pc[e_rd]  : '0;
  assign fq.out_instr = out_valid_c ? e_ins[e_rd] : '0;
  assign fq.count     = e_cnt;
  assign fq.full      = (e_cnt == CNT_W'(DEPTH));
  assign fq.empty     = (e_cnt == '0);

  // control state: pointers and counters update net; redirect overrides all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
      fpc      <= RESET_PC;
      e_wr     <= '0;
      e_rd     <= '0;
      e_cnt    <= '0;
      p_wr     <= '0;
      p_rd     <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      run <= 1'b1;
      if (fq.redirect) begin
        fpc      <= fq.redirect_pc;
        e_wr     <= '0;
        e_rd     <= '0;
        e_cnt    <= '0;
        p_wr     <= '0;
        p_rd     <= '0;
        inflight <= '0;
        drop     <= drop_redir;
      end else begin
        if (issue) begin
          fpc  <= fpc + PC_W'(4);
          p_wr <= p_wr + PTR_W'(1);
        end
        if (rsp_take) begin
          p_rd <= p_rd + PTR_W'(1);
          e_wr <= e_wr + PTR_W'(1);
        end
        if (accept) begin
          e_rd <= e_rd + PTR_W'(1);
        end
        e_cnt    <= e_cnt + CNT_W'(rsp_take) - CNT_W'(accept);
        inflight <= inflight + CNT_W'(issue) - CNT_W'(rsp_take);
        if (rsp_drop) begin
          drop <= drop - CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents are only observed through valid pointers/counts
  always_ff @(posedge clk) begin
    if (issue) begin
      p_pc[p_wr] <= fpc;
    end
    if (rsp_take && !fq.redirect) begin
      e_pc[e_wr]  <= p_pc[p_rd];
      e_ins[e_wr] <= fq.imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] ins;
  } ent_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } mrsp_t;

  logic clk;
  logic reset;

  fetch_queue_if #(.PC_W(9), .INS_W(32), .CNT_W(3)) bus ();

  fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(9'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  ent_t  exp_q[$];
  mrsp_t mem_q[$];
  int    edge_n = 0;
  int    lat = 1;
  int    nreq = 0;
  logic  spur = 1'b0;
  logic  head_drv = 1'b0;
  logic  req_s = 1'b0;
  logic [8:0] addr_s = '0;
  logic [7:0] gen = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [7:0] g, input logic [8:0] a);
    return {g, 8'hC3, 7'h00, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [8:0] pc);
    ent_t e;
    e.pc  = pc;
    e.ins = mk(gen, pc);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int l, input logic rdy);
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = rdy;
    lat             = l;
    spur            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    gen   = gen + 8'h01;
    nreq  = 0;
    reset = 1'b1;
  endtask

  // request sampler, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      req_s  = bus.imem_req;
      addr_s = bus.imem_addr;
    end
  end

  // in-order memory with fixed latency lat; spur injects an unsolicited response
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      mrsp_t m;
      @(posedge clk);
      edge_n++;
      if (!reset) begin
        mem_q.delete();
      end else begin
        if (head_drv) void'(mem_q.pop_front());
        if (req_s) begin
          m.due  = edge_n + lat - 1;
          m.data = mk(gen, addr_s);
          mem_q.push_back(m);
          nreq++;
        end
      end
      #2;
      head_drv = 1'b0;
      if (reset && mem_q.size() > 0) begin
        if (mem_q[0].due <= edge_n) head_drv = 1'b1;
      end
      bus.imem_rvalid = head_drv || spur;
      if (head_drv)  bus.imem_rdata = mem_q[0].data;
      else if (spur) bus.imem_rdata = 32'hDEADBEEF;
      else           bus.imem_rdata = '0;
    end
  end

  // monitor: every accepted entry must be the next expected one
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL accept_unexpected: got pc %h instr %h, expected nothing", bus.out_pc, bus.out_instr);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if (bus.out_pc !== e.pc || bus.out_instr !== e.ins) begin
            n_bad++;
            $display("FAIL accept: got pc %h instr %h expected pc %h instr %h",
                     bus.out_pc, bus.out_instr, e.pc, e.ins);
          end
        end
      end
    end
  end

  initial begin
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;

    // 1: streaming from RESET_PC with 1-cycle memory
    do_reset(1, 1'b1);
    #2;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    for (int k = 0; k < 8; k++) expect_pc(9'(4 * k));
    tick(1); #2;
    chk("t1_req_e1", 32'(bus.imem_req), 32'd1);
    chk("t1_addr_e1", 32'(bus.imem_addr), 32'h000);
    tick(1); #2;
    chk("t1_addr_e2", 32'(bus.imem_addr), 32'h004);
    chk("t1_valid_e2", 32'(bus.out_valid), 32'd0);
    tick(1); #2;
    chk("t1_valid_e3", 32'(bus.out_valid), 32'd1);
    tick(8);
    bus.out_ready = 1'b0;
    tick(1); #2;
    chk("t1_drained", exp_q.size(), 0);

    // 2: stall fills the queue; unsolicited response ignored; drain resumes fetch
    do_reset(1, 1'b0);
    tick(8);
    spur = 1'b1;
    #2;
    chk("t2_count_full", 32'(bus.count), 32'd4);
    chk("t2_full", 32'(bus.full), 32'd1);
    chk("t2_req_stall", 32'(bus.imem_req), 32'd0);
    chk("t2_nreq", nreq, 4);
    tick(1);
    spur = 1'b0;
    #2;
    chk("t2_count_spur", 32'(bus.count), 32'd4);
    chk("t2_head_pc", 32'(bus.out_pc), 32'h000);
    chk("t2_head_instr", bus.out_instr, mk(gen, 9'h000));
    tick(1);
    for (int k = 0; k < 6; k++) expect_pc(9'(4 * k));
    bus.out_ready = 1'b1;
    #2;
    chk("t2_req_before_pop", 32'(bus.imem_req), 32'd0);
    tick(1); #2;
    chk("t2_req_resume", 32'(bus.imem_req), 32'd1);
    chk("t2_addr_resume", 32'(bus.imem_addr), 32'h010);
    tick(5);
    bus.out_ready = 1'b0;
    tick(1); #2;
    chk("t2_drained", exp_q.size(), 0);

    // 3: 3-cycle memory, redirect with two requests in flight
    do_reset(3, 1'b1);
    tick(3);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h040;
    #2;
    chk("t3_req_redir", 32'(bus.imem_req), 32'd0);
    chk("t3_valid_redir", 32'(bus.out_valid), 32'd0);
    tick(1);
    bus.redirect = 1'b0;
    #2;
    chk("t3_req_after", 32'(bus.imem_req), 32'd1);
    chk("t3_addr_after", 32'(bus.imem_addr), 32'h040);
    expect_pc(9'h040);
    expect_pc(9'h044);
    expect_pc(9'h048);
    tick(3); #2;
    chk("t3_stale_not_queued", 32'(bus.out_valid), 32'd0);
    tick(4);
    bus.out_ready = 1'b0;
    tick(1); #2;
    chk("t3_drained", exp_q.size(), 0);

    // 4: redirect while decode is ready and two entries are stored
    do_reset(1, 1'b0);
    tick(4);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h100;
    bus.out_ready   = 1'b1;
    #2;
    chk("t4_count_before", 32'(bus.count), 32'd2);
    chk("t4_valid_redir", 32'(bus.out_valid), 32'd0);
    chk("t4_pc_redir", 32'(bus.out_pc), 32'd0);
    chk("t4_req_redir", 32'(bus.imem_req), 32'd0);
    tick(1);
    bus.redirect = 1'b0;
    #2;
    chk("t4_count_after", 32'(bus.count), 32'd0);
    chk("t4_empty_after", 32'(bus.empty), 32'd1);
    chk("t4_addr_after", 32'(bus.imem_addr), 32'h100);
    expect_pc(9'h100);
    expect_pc(9'h104);
    tick(4);
    bus.out_ready = 1'b0;
    tick(1); #2;
    chk("t4_drained", exp_q.size(), 0);

    // 5: fetch address wraps at the top of the PC space
    do_reset(1, 1'b1);
    tick(1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 9'h1F8;
    #2;
    chk("t5_req_redir", 32'(bus.imem_req), 32'd0);
    tick(1);
    bus.redirect = 1'b0;
    #2;
    chk("t5_addr_1f8", 32'(bus.imem_addr), 32'h1F8);
    expect_pc(9'h1F8);
    expect_pc(9'h1FC);
    expect_pc(9'h000);
    expect_pc(9'h004);
    tick(1); #2;
    chk("t5_addr_1fc", 32'(bus.imem_addr), 32'h1FC);
    tick(1); #2;
    chk("t5_addr_wrap", 32'(bus.imem_addr), 32'h000);
    tick(4);
    bus.out_ready = 1'b0;
    tick(1); #2;
    chk("t5_drained", exp_q.size(), 0);

    // 6: reset asserted mid-stream with entries stored and requests in flight
    do_reset(3, 1'b0);
    tick(6); #2;
    chk("t6_count_before", 32'(bus.count), 32'd2);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_req_async", 32'(bus.imem_req), 32'd0);
    chk("t6_valid_async", 32'(bus.out_valid), 32'd0);
    chk("t6_pc_async", 32'(bus.out_pc), 32'd0);
    chk("t6_instr_async", bus.out_instr, 32'd0);
    chk("t6_count_async", 32'(bus.count), 32'd0);
    chk("t6_empty_async", 32'(bus.empty), 32'd1);
    do_reset(1, 1'b1);
    expect_pc(9'h000);
    expect_pc(9'h004);
    tick(1); #2;
    chk("t6_addr_restart", 32'(bus.imem_addr), 32'h000);
    tick(4);
    bus.out_ready = 1'b0;
    tick(1); #2;
    chk("t6_drained", exp_q.size(), 0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
